// File: rtl/soc_msp430_trace_monitor.sv
// Per-core trace monitor: decodes simulation-event instructions into a buffered event stream.
// Optional TRACE_MON_PERF_EN adds retired-instruction and accepted-event counters.
module soc_msp430_trace_monitor #(
   parameter int unsigned XLEN       = 16,
   parameter int unsigned SHADOW_REG = 3,
   parameter logic [7:0]  EVT_PREFIX = 8'h43,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            trace_valid,
   input  logic [XLEN-1:0] trace_pc,
   input  logic [XLEN-1:0] trace_insn,
   input  logic            trace_wben,
   input  logic [3:0]      trace_wbreg,
   input  logic [XLEN-1:0] trace_wbdata,
   output logic            evt_valid,
   input  logic            evt_ready,
   output logic [1:0]      evt_type,
   output logic [XLEN-1:0] evt_data,
   output logic [XLEN-1:0] evt_pc,
   output logic            overflow,
   output logic            termination,
   output logic [XLEN-1:0] shadow_r
`ifdef TRACE_MON_PERF_EN
   ,
   output logic [31:0]     insn_count,
   output logic [15:0]     evt_count
`endif
);

   localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned CW = AW + 1;
   localparam logic [CW-1:0] FULL_COUNT = CW'(FIFO_DEPTH);

   typedef enum logic [1:0] {RUN, DRAIN, DONE} state_t;
   typedef enum logic [1:0] {EVT_PUTC = 2'd0, EVT_REPORT = 2'd1, EVT_EXIT = 2'd2} evt_kind_t;

   state_t          state, state_next;
   logic [AW-1:0]   wr_ptr, rd_ptr;
   logic [CW-1:0]   count;
   logic [1:0]      mem_type [FIFO_DEPTH];
   logic [XLEN-1:0] mem_data [FIFO_DEPTH];
   logic [XLEN-1:0] mem_pc   [FIFO_DEPTH];

   logic            push_req, push, pop, full;
   evt_kind_t       push_type;
   logic [XLEN-1:0] push_data;

   // Operand is the shadow value held before this retirement, even if it also writes the shadow reg.
   always_comb begin
      push_req  = 1'b0;
      push_type = EVT_PUTC;
      push_data = shadow_r;
      if (trace_valid && state == RUN && trace_insn[15:8] == EVT_PREFIX) begin
         case (trace_insn[7:0])
            8'h04: begin
               push_req  = 1'b1;
               push_type = EVT_PUTC;
               push_data = {{(XLEN-8){1'b0}}, shadow_r[7:0]};
            end
            8'h02: begin
               push_req  = 1'b1;
               push_type = EVT_REPORT;
            end
            8'h01: begin
               push_req  = 1'b1;
               push_type = EVT_EXIT;
            end
            default: ;
         endcase
      end
   end

   assign evt_valid   = (count != '0);
   assign full        = (count == FULL_COUNT);
   assign pop         = evt_valid && evt_ready;
   assign push        = push_req && (!full || pop);
   assign evt_type    = evt_valid ? mem_type[rd_ptr] : '0;
   assign evt_data    = evt_valid ? mem_data[rd_ptr] : '0;
   assign evt_pc      = evt_valid ? mem_pc[rd_ptr]   : '0;
   assign termination = (state == DONE);

   always_comb begin
      state_next = state;
      case (state)
         RUN:     if (push && push_type == EVT_EXIT) state_next = DRAIN;
         DRAIN:   if (count == '0) state_next = DONE;
         DONE:    state_next = DONE;
         default: state_next = RUN;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= RUN;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
         shadow_r <= '0;
      end else begin
         state <= state_next;
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
         if (push_req && full && !pop) overflow <= 1'b1;
         if (trace_valid && trace_wben && trace_wbreg == 4'(SHADOW_REG))
            shadow_r <= trace_wbdata;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem_type[wr_ptr] <= push_type;
         mem_data[wr_ptr] <= push_data;
         mem_pc[wr_ptr]   <= trace_pc;
      end
   end

`ifdef TRACE_MON_PERF_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         insn_count <= '0;
         evt_count  <= '0;
      end else begin
         if (trace_valid && state != DONE && insn_count != '1) insn_count <= insn_count + 32'd1;
         if (push) evt_count <= evt_count + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_soc_msp430_trace_monitor.sv
// Directed bench for soc_msp430_trace_monitor: queue-based event model checked every cycle plus literal expectations.
module tb_soc_msp430_trace_monitor;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        trace_valid = 1'b0;
   logic [15:0] trace_pc = '0;
   logic [15:0] trace_insn = '0;
   logic        trace_wben = 1'b0;
   logic [3:0]  trace_wbreg = '0;
   logic [15:0] trace_wbdata = '0;
   logic        evt_valid;
   logic        evt_ready = 1'b0;
   logic [1:0]  evt_type;
   logic [15:0] evt_data;
   logic [15:0] evt_pc;
   logic        overflow;
   logic        termination;
   logic [15:0] shadow_r;
`ifdef TRACE_MON_PERF_EN
   logic [31:0] insn_count;
   logic [15:0] evt_count;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   soc_msp430_trace_monitor #(
      .XLEN(16),
      .SHADOW_REG(3),
      .EVT_PREFIX(8'h43),
      .FIFO_DEPTH(DEPTH)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .trace_valid(trace_valid),
      .trace_pc(trace_pc),
      .trace_insn(trace_insn),
      .trace_wben(trace_wben),
      .trace_wbreg(trace_wbreg),
      .trace_wbdata(trace_wbdata),
      .evt_valid(evt_valid),
      .evt_ready(evt_ready),
      .evt_type(evt_type),
      .evt_data(evt_data),
      .evt_pc(evt_pc),
      .overflow(overflow),
      .termination(termination),
      .shadow_r(shadow_r)
`ifdef TRACE_MON_PERF_EN
      ,
      .insn_count(insn_count),
      .evt_count(evt_count)
`endif
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model: a queue of pending events plus run/drain/done flags
   typedef struct {
      logic [1:0]  t;
      logic [15:0] d;
      logic [15:0] pc;
   } ev_t;

   ev_t         mq[$];
   bit          m_drain, m_done, m_ovf;
   logic [15:0] m_shadow;
   logic [31:0] m_insn;
   logic [15:0] m_evtc;

   always @(posedge clk or negedge rst_n) begin : model
      int  n;
      bit  pop_now, done_now, req;
      ev_t e;
      if (!rst_n) begin
         mq.delete();
         m_drain  = 0;
         m_done   = 0;
         m_ovf    = 0;
         m_shadow = '0;
         m_insn   = '0;
         m_evtc   = '0;
      end else begin
         n        = mq.size();
         pop_now  = (n > 0) && evt_ready;
         done_now = m_drain && (n == 0);
         if (trace_valid && !m_done && m_insn != 32'hFFFF_FFFF) m_insn = m_insn + 1;
         req  = 0;
         e.t  = 2'd0;
         e.pc = trace_pc;
         e.d  = m_shadow;
         if (trace_valid && !m_drain && !m_done && trace_insn[15:8] == 8'h43) begin
            if (trace_insn[7:0] == 8'h04) begin
               req = 1; e.t = 2'd0; e.d = {8'h00, m_shadow[7:0]};
            end else if (trace_insn[7:0] == 8'h02) begin
               req = 1; e.t = 2'd1;
            end else if (trace_insn[7:0] == 8'h01) begin
               req = 1; e.t = 2'd2;
            end
         end
         if (pop_now) void'(mq.pop_front());
         if (req) begin
            if (n < DEPTH || pop_now) begin
               mq.push_back(e);
               m_evtc = m_evtc + 16'd1;
               if (e.t == 2'd2) m_drain = 1;
            end else begin
               m_ovf = 1;
            end
         end
         if (done_now) begin
            m_done  = 1;
            m_drain = 0;
         end
         if (trace_valid && trace_wben && trace_wbreg == 4'd3) m_shadow = trace_wbdata;
      end
   end

   always @(negedge clk) begin
      if (rst_n) begin
         check("evt_valid", evt_valid, mq.size() != 0);
         if (mq.size() != 0) begin
            check("evt_type", evt_type, mq[0].t);
            check("evt_data", evt_data, mq[0].d);
            check("evt_pc", evt_pc, mq[0].pc);
         end
         check("overflow", overflow, m_ovf);
         check("termination", termination, m_done);
         check("shadow_r", shadow_r, m_shadow);
`ifdef TRACE_MON_PERF_EN
         check("insn_count", insn_count, m_insn);
         check("evt_count", evt_count, m_evtc);
`endif
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic retire(input logic [15:0] pc, input logic [15:0] insn, input logic wben,
                         input logic [15:0] wbdata);
      trace_valid  = 1'b1;
      trace_pc     = pc;
      trace_insn   = insn;
      trace_wben   = wben;
      trace_wbreg  = 4'd3;
      trace_wbdata = wbdata;
      step();
      trace_valid = 1'b0;
      trace_wben  = 1'b0;
   endtask

   task automatic reset_pulse();
      #2;
      rst_n = 1'b0;
      #1;
      check("rst_evt_valid", evt_valid, 0);
      check("rst_overflow", overflow, 0);
      check("rst_termination", termination, 0);
      trace_valid = 1'b0;
      evt_ready   = 1'b0;
      step();
      rst_n = 1'b1;
   endtask

   task automatic drain(input logic [15:0] first_pc, output int popped);
      popped = 0;
      evt_ready = 1'b1;
      for (int i = 0; i < 2 * DEPTH; i++) begin
         if (evt_valid) begin
            check("drain_order", evt_pc, first_pc + 16'(2 * popped));
            popped++;
         end
         step();
      end
      evt_ready = 1'b0;
   endtask

   initial begin
      int popped;
      repeat (2) @(posedge clk);
      #1;
      check("reset_evt_valid", evt_valid, 0);
      check("reset_overflow", overflow, 0);
      check("reset_termination", termination, 0);
      check("reset_shadow", shadow_r, 0);
      check("reset_evt_data", evt_data, 0);
      rst_n = 1'b1;
      step();

      // putc with r3 = 0x0041, one cycle latency
      retire(16'h0100, 16'h4000, 1'b1, 16'h0041);
      check("t1_before", evt_valid, 0);
      retire(16'h0102, 16'h4304, 1'b0, 16'h0000);
      check("t1_valid", evt_valid, 1);
      check("t1_type", evt_type, 0);
      check("t1_data", evt_data, 16'h0041);
      evt_ready = 1'b1;
      step();
      evt_ready = 1'b0;
      check("t1_popped", evt_valid, 0);

      // putc truncates to a byte; report in the same cycle as a shadow write sees the old value
      retire(16'h0104, 16'h4000, 1'b1, 16'h1234);
      retire(16'h0110, 16'h4304, 1'b0, 16'h0000);
      retire(16'h0112, 16'h4302, 1'b1, 16'h5555);
      retire(16'h0114, 16'h4377, 1'b0, 16'h0000);
      retire(16'h0116, 16'h4404, 1'b0, 16'h0000);
      trace_insn = 16'h4304;
      step();
      check("t1b_putc_data", evt_data, 16'h0034);
      check("t1b_shadow", shadow_r, 16'h5555);
      evt_ready = 1'b1;
      step();
      evt_ready = 1'b0;
      check("t1b_report_data", evt_data, 16'h1234);
      check("t1b_report_type", evt_type, 1);
      check("t1b_report_pc", evt_pc, 16'h0112);
      evt_ready = 1'b1;
      step();
      evt_ready = 1'b0;
      check("t1b_empty", evt_valid, 0);

      // five reports into a four-deep FIFO
      for (int i = 0; i < 5; i++) retire(16'h0200 + 16'(2 * i), 16'h4302, 1'b0, 16'h0000);
      check("t2_overflow", overflow, 1);
      drain(16'h0200, popped);
      check("t2_popped", popped, 4);
      check("t2_overflow_sticky", overflow, 1);
      reset_pulse();

      // push and pop on a full FIFO in the same cycle
      for (int i = 0; i < 4; i++) retire(16'h0400 + 16'(2 * i), 16'h4302, 1'b0, 16'h0000);
      check("t4_full_ovf", overflow, 0);
      evt_ready = 1'b1;
      retire(16'h0408, 16'h4302, 1'b0, 16'h0000);
      evt_ready = 1'b0;
      check("t4_overflow", overflow, 0);
      drain(16'h0402, popped);
      check("t4_count", popped, 4);
      reset_pulse();

      // exit then drain to termination
      retire(16'h0300, 16'h4000, 1'b1, 16'h0007);
      evt_ready = 1'b1;
      retire(16'h0302, 16'h4301, 1'b0, 16'h0000);
      check("t3_exit_type", evt_type, 2);
      check("t3_exit_data", evt_data, 16'h0007);
      check("t3_term_early", termination, 0);
      step();
      check("t3_popped", evt_valid, 0);
      check("t3_term_pop", termination, 0);
      step();
      check("t3_term", termination, 1);
      retire(16'h0310, 16'h4304, 1'b0, 16'h0000);
      retire(16'h0312, 16'h4301, 1'b0, 16'h0000);
      check("t3_ignored", evt_valid, 0);
      retire(16'h0314, 16'h4000, 1'b1, 16'h00AA);
      check("t3_shadow", shadow_r, 16'h00AA);
      check("t3_term_held", termination, 1);
      reset_pulse();

      // reset while draining with two queued
      retire(16'h0500, 16'h4000, 1'b1, 16'h0009);
      retire(16'h0502, 16'h4302, 1'b0, 16'h0000);
      retire(16'h0504, 16'h4301, 1'b0, 16'h0000);
      retire(16'h0506, 16'h4302, 1'b0, 16'h0000);
      check("t5_queued", evt_valid, 1);
      reset_pulse();
      retire(16'h0510, 16'h4304, 1'b0, 16'h0000);
      check("t5_run_valid", evt_valid, 1);
      check("t5_run_pc", evt_pc, 16'h0510);
      check("t5_run_data", evt_data, 16'h0000);

`ifdef TRACE_MON_PERF_EN
      reset_pulse();
      evt_ready = 1'b1;
      for (int i = 0; i < 10; i++)
         retire(16'h0600 + 16'(2 * i),
                (i == 2) ? 16'h4304 : ((i == 5 || i == 7) ? 16'h4302 : 16'h4000), 1'b0, 16'h0000);
      step();
      check("t6_insn_count", insn_count, 10);
      check("t6_evt_count", evt_count, 3);
`endif

      repeat (3) step();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
